score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/crossy_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 70 +++++++
 rtl/score_keeper.sv | 120 ++++++++++++
 tb/tb_score_keeper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/crossy_pkg.sv
// Shared widths, mode and converter state encodings, and the double-dabble
// step used by the score BCD converter.
package crossy_pkg;

    localparam int SCORE_W  = 8;
    localparam int BCD_W    = 4;
    localparam int BCD_DIGS = 3;
    localparam int DABBLE_W = BCD_DIGS * BCD_W + SCORE_W;

    localparam logic [1:0] BCD_IDLE  = 2'd0;
    localparam logic [1:0] BCD_LOAD  = 2'd1;
    localparam logic [1:0] BCD_SHIFT = 2'd2;
    localparam logic [1:0] BCD_DONE  = 2'd3;

    localparam logic MODE_PLAY = 1'b1;
    localparam logic MODE_OVER = 1'b0;

    typedef struct packed {
        logic [BCD_W-1:0] hundreds;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_digits_t;

    // One double-dabble iteration: bias every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [DABBLE_W-1:0] dabble_step(input logic [DABBLE_W-1:0] w);
        logic [DABBLE_W-1:0] a;
        a = w;
        for (int n = 0; n < BCD_DIGS; n++) begin
            if (a[SCORE_W + n*BCD_W +: BCD_W] >= 4'd5) begin
                a[SCORE_W + n*BCD_W +: BCD_W] = a[SCORE_W + n*BCD_W +: BCD_W] + 4'd3;
            end else begin
                a[SCORE_W + n*BCD_W +: BCD_W] = a[SCORE_W + n*BCD_W +: BCD_W];
            end
        end
        return {a[DABBLE_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD, eight SHIFT cycles, DONE commit.
// i_start restarts from LOAD in any state, so a stale result is never committed.
module bin2bcd_seq
    import crossy_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_bin,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_hundreds,
    output logic [BCD_W-1:0]   o_tens,
    output logic [BCD_W-1:0]   o_ones
);

    logic [1:0]          r_state;
    logic [2:0]          r_cnt;
    logic [DABBLE_W-1:0] r_work;
    bcd_digits_t         r_digits;

    // Converter FSM with work register and committed digit register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= BCD_IDLE;
            r_cnt    <= 3'd0;
            r_work   <= {DABBLE_W{1'b0}};
            r_digits <= '0;
        end else if (i_start) begin
            r_state <= BCD_LOAD;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                BCD_IDLE: begin
                    r_state <= BCD_IDLE;
                end
                BCD_LOAD: begin
                    r_work  <= {{(BCD_DIGS*BCD_W){1'b0}}, i_bin};
                    r_cnt   <= 3'd0;
                    r_state <= BCD_SHIFT;
                end
                BCD_SHIFT: begin
                    r_work <= dabble_step(r_work);
                    if (r_cnt == 3'd7) begin
                        r_cnt   <= 3'd0;
                        r_state <= BCD_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= BCD_SHIFT;
                    end
                end
                BCD_DONE: begin
                    r_digits <= bcd_digits_t'(r_work[DABBLE_W-1 -: BCD_DIGS*BCD_W]);
                    r_state  <= BCD_IDLE;
                end
                default: begin
                    r_state <= BCD_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != BCD_IDLE);
    assign o_done     = (r_state == BCD_DONE);
    assign o_hundreds = r_digits.hundreds;
    assign o_tens     = r_digits.tens;
    assign o_ones     = r_digits.ones;

endmodule

// File: rtl/score_keeper.sv
// Score keeper: game mode, frame divider, saturating score, high score and a
// change-triggered sequential BCD conversion of the score.
module score_keeper
    import crossy_pkg::*;
#(
    parameter int INC_PERIOD_FRAMES = 8,
    parameter int SCORE_MAX         = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_tick,
    input  logic               i_move,
    input  logic               i_game_start,
    input  logic               i_game_over,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score,
    output logic [BCD_W-1:0]   o_bcd_hundreds,
    output logic [BCD_W-1:0]   o_bcd_tens,
    output logic [BCD_W-1:0]   o_bcd_ones,
    output logic               o_bcd_valid
);

    localparam logic [SCORE_W-1:0] DIV_LAST  = SCORE_W'(INC_PERIOD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    logic               r_mode;
    logic [SCORE_W-1:0] r_div;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic               r_hs_pend;
    logic [SCORE_W-1:0] r_req;
    logic               r_bcd_valid;

    logic               w_start;
    logic               w_bcd_busy;
    logic               w_bcd_done;
    logic [BCD_W-1:0]   w_hundreds;
    logic [BCD_W-1:0]   w_tens;
    logic [BCD_W-1:0]   w_ones;

    // Game mode, frame divider, score and high score.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode    <= MODE_PLAY;
            r_div     <= {SCORE_W{1'b0}};
            r_score   <= {SCORE_W{1'b0}};
            r_high    <= {SCORE_W{1'b0}};
            r_hs_pend <= 1'b0;
        end else begin
            r_hs_pend <= i_game_over & ~i_game_start;
            if (r_hs_pend && (r_score > r_high)) begin
                r_high <= r_score;
            end else begin
                r_high <= r_high;
            end

            if (i_game_start) begin
                r_mode  <= MODE_PLAY;
                r_div   <= {SCORE_W{1'b0}};
                r_score <= {SCORE_W{1'b0}};
            end else if (i_game_over) begin
                r_mode <= MODE_OVER;
            end else if ((r_mode == MODE_PLAY) && i_frame_tick) begin
                if (!i_move) begin
                    r_div <= {SCORE_W{1'b0}};
                end else if (r_div >= DIV_LAST) begin
                    // divider keeps wrapping at saturation; only the score stops
                    r_div <= {SCORE_W{1'b0}};
                    if (r_score < SCORE_TOP) begin
                        r_score <= r_score + 8'd1;
                    end else begin
                        r_score <= r_score;
                    end
                end else begin
                    r_div <= r_div + 8'd1;
                end
            end else begin
                r_div <= r_div;
            end
        end
    end

    // A score differing from the last requested value (re)starts conversion.
    assign w_start = (r_score != r_req);

    // Last requested value and the digit-valid flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req       <= {SCORE_W{1'b0}};
            r_bcd_valid <= 1'b1;
        end else if (w_start) begin
            r_req       <= r_score;
            r_bcd_valid <= 1'b0;
        end else if (w_bcd_done || !w_bcd_busy) begin
            r_bcd_valid <= 1'b1;
        end else begin
            r_bcd_valid <= r_bcd_valid;
        end
    end

    bin2bcd_seq u_bcd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_start),
        .i_bin      (r_score),
        .o_busy     (w_bcd_busy),
        .o_done     (w_bcd_done),
        .o_hundreds (w_hundreds),
        .o_tens     (w_tens),
        .o_ones     (w_ones)
    );

    assign o_score        = r_score;
    assign o_high_score   = r_high;
    assign o_bcd_hundreds = w_hundreds;
    assign o_bcd_tens     = w_tens;
    assign o_bcd_ones     = w_ones;
    assign o_bcd_valid    = r_bcd_valid;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed corner sequences
// and random stimulus, all compared against a behavioural model.
module tb_score_keeper;

    localparam int INC  = 8;
    localparam int SMAX = 255;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1, i_frame_tick = 1'b0, i_move = 1'b0;
    logic       i_game_start = 1'b0, i_game_over = 1'b0;
    logic [7:0] o_score, o_high_score;
    logic [3:0] o_bcd_hundreds, o_bcd_tens, o_bcd_ones;
    logic       o_bcd_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_keeper #(.INC_PERIOD_FRAMES(INC), .SCORE_MAX(SMAX)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_frame_tick   (i_frame_tick),
        .i_move         (i_move),
        .i_game_start   (i_game_start),
        .i_game_over    (i_game_over),
        .o_score        (o_score),
        .o_high_score   (o_high_score),
        .o_bcd_hundreds (o_bcd_hundreds),
        .o_bcd_tens     (o_bcd_tens),
        .o_bcd_ones     (o_bcd_ones),
        .o_bcd_valid    (o_bcd_valid)
    );

    // behavioural model state
    int m_score = 0, m_high = 0, m_ticks = 0, m_cnt = 0, m_target = 0;
    int m_h = 0, m_t = 0, m_o = 0;
    bit m_play = 1'b1, m_hs_pend = 1'b0, m_chg = 1'b0, m_valid = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, tick, move, start, over);
        int old;
        if (rst) begin
            m_score = 0; m_high = 0; m_ticks = 0; m_cnt = 0; m_target = 0;
            m_h = 0; m_t = 0; m_o = 0;
            m_play = 1'b1; m_hs_pend = 1'b0; m_chg = 1'b0; m_valid = 1'b1;
            return;
        end
        // digits appear 11 edges after the latest score change
        if (m_chg) begin
            m_valid = 1'b0; m_cnt = 10; m_target = m_score;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_h = m_target / 100; m_t = (m_target / 10) % 10; m_o = m_target % 10;
                m_valid = 1'b1;
            end
        end
        if (m_hs_pend && m_score > m_high) m_high = m_score;
        m_hs_pend = over && !start;
        old = m_score;
        if (start) begin
            m_score = 0; m_ticks = 0; m_play = 1'b1;
        end else if (over) begin
            m_play = 1'b0;
        end else if (m_play && tick) begin
            if (move) begin
                m_ticks++;
                if (m_ticks == INC) begin
                    m_ticks = 0;
                    if (m_score < SMAX) m_score++;
                end
            end else begin
                m_ticks = 0;
            end
        end
        m_chg = (m_score != old);
    endtask

    task automatic step(input bit rst, tick, move, start, over);
        @(negedge clk);
        i_rst = rst; i_frame_tick = tick; i_move = move;
        i_game_start = start; i_game_over = over;
        @(posedge clk);
        model_edge(rst, tick, move, start, over);
        #1;
        chk("score", o_score, m_score);
        chk("high", o_high_score, m_high);
        chk("valid", o_bcd_valid, m_valid);
        chk("hundreds", o_bcd_hundreds, m_h);
        chk("tens", o_bcd_tens, m_t);
        chk("ones", o_bcd_ones, m_o);
    endtask

    typedef struct {
        bit rst, tick, move, start, over;
        int score, high;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, tick, move, start, over, input int sc, hi, reps);
        vec_t v;
        v.rst = rst; v.tick = tick; v.move = move; v.start = start; v.over = over;
        v.score = sc; v.high = hi;
        for (int k = 0; k < reps; k++) tbl.push_back(v);
    endtask

    initial begin
        bit saw99;
        bit mv;
        int r;
        bit rs, tk, st, ov;

        // rst tick move start over -> score high, repeat count
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 7);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 7);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 2);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 7);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].tick, tbl[i].move, tbl[i].start, tbl[i].over);
            chk($sformatf("tbl%0d_score", i), o_score, tbl[i].score);
            chk($sformatf("tbl%0d_high", i), o_high_score, tbl[i].high);
        end
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tbl_bcd_ones", o_bcd_ones, 1);
        chk("tbl_valid", o_bcd_valid, 1);

        // count up to 2 and check the valid-low window after the second increment
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("two_score", o_score, 2);
        for (int k = 1; k <= 11; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("two_valid_e%0d", k), o_bcd_valid, (k == 11) ? 1 : 0);
        end
        chk("two_ones", o_bcd_ones, 2);
        chk("two_tens", o_bcd_tens, 0);

        // saturation at 255
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (256 * INC + 16) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_score", o_score, 255);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_h", o_bcd_hundreds, 2);
        chk("sat_t", o_bcd_tens, 5);
        chk("sat_o", o_bcd_ones, 5);
        chk("sat_valid", o_bcd_valid, 1);

        // game over at 137, then restart
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (137 * INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("go_score", o_score, 137);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("go_high_before", o_high_score, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("go_high_after", o_high_score, 137);
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("go_score_hold", o_score, 137);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart_score", o_score, 0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_valid_low", o_bcd_valid, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_valid", o_bcd_valid, 1);
        chk("restart_digits", {o_bcd_hundreds, o_bcd_tens, o_bcd_ones}, 0);
        chk("restart_high", o_high_score, 137);

        // simultaneous start and over at score 40
        repeat (40 * INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_pre", o_score, 40);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("both_score", o_score, 0);
        repeat (INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_play", o_score, 1);
        chk("both_high", o_high_score, 137);

        // restart four edges after reaching 99
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (98 * INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ab_score", o_score, 99);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        saw99 = 1'b0;
        repeat (15) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (o_bcd_tens == 4'd9 && o_bcd_ones == 4'd9) saw99 = 1'b1;
        end
        chk("ab_no99", saw99, 0);
        chk("ab_valid", o_bcd_valid, 1);
        chk("ab_digits", {o_bcd_hundreds, o_bcd_tens, o_bcd_ones}, 0);

        // reset in the middle of a conversion
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (INC) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_busy", o_bcd_valid, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_score", o_score, 0);
        chk("rst_mid_valid", o_bcd_valid, 1);
        chk("rst_mid_digits", {o_bcd_hundreds, o_bcd_tens, o_bcd_ones}, 0);
        repeat (15) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_after", {o_bcd_hundreds, o_bcd_tens, o_bcd_ones}, 0);

        // random stimulus
        mv = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r  = int'($urandom_range(0, 999));
            tk = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) mv = ~mv;
            rs = (r < 2);
            st = (r >= 2 && r < 8);
            ov = (r >= 8 && r < 14) && !tk;
            step(rs, tk, mv, st, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
